// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state encoding, defaults and round-robin helper for the
// source-side 4-phase CDC channel and its synchronizers.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } cdc_state_e;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // Widest requester set the helper handles, and the index width that covers it.
  localparam int MAX_REQ = 16;
  localparam int GRANT_W = 4;
  localparam int IDX_W   = GRANT_W + 1;

  // Round-robin scan: returns {found, index} of the first set bit of valid,
  // looking at ptr+1, ptr+2, ... and wrapping at num_req. Bits of valid at or
  // above num_req must be zero.
  function automatic logic [GRANT_W:0] rr_next_grant(
    input logic [MAX_REQ-1:0] valid,
    input logic [GRANT_W-1:0] ptr,
    input logic [IDX_W-1:0]   num_req
  );
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic [GRANT_W-1:0] grant;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = {1'b0, ptr} + IDX_W'(k);
      if (idx >= num_req) begin
        idx = idx - num_req;
      end
      if (!found && (IDX_W'(k) <= num_req) && valid[idx[GRANT_W-1:0]]) begin
        found = 1'b1;
        grant = idx[GRANT_W-1:0];
      end
    end
    return {found, grant};
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain: single-bit multi-flop synchronizer with async active-low
// reset. Used for the returning ack here and for req on the receiving side.
module sync_ff_chain
  import cdc_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain; the last flop is the synchronized copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_channel_arbiter.sv
// cdc_channel_arbiter: shares one 4-phase req/ack crossing among NUM_REQ
// local requesters. A round-robin winner is accepted in IDLE, its word and
// index are registered onto the channel, and the handshake completes against
// the synchronized ack before the next winner can be taken.
module cdc_channel_arbiter
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = $clog2(NUM_REQ),
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ready,
  output logic                          o_cdc_req,
  output logic [DATA_WIDTH-1:0]         o_cdc_data,
  output logic [ID_WIDTH-1:0]           o_cdc_id,
  input  logic                          i_cdc_ack,
  output logic                          o_busy
);

  cdc_state_e            state;
  logic [GRANT_W-1:0]    ptr;
  logic                  ack_s;
  logic [GRANT_W:0]      rr_result;
  logic                  grant_found;
  logic                  grant_en;
  logic [GRANT_W-1:0]    grant_idx;
  logic [DATA_WIDTH-1:0] grant_word;

  sync_ff_chain #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (i_clk),
    .rst_n(i_rst),
    .d    (i_cdc_ack),
    .q    (ack_s)
  );

  // Choose the next requester after the last winner; only accept in IDLE once the ack has settled low
  always_comb begin
    rr_result   = rr_next_grant(MAX_REQ'(i_valid), ptr, IDX_W'(NUM_REQ));
    grant_found = rr_result[GRANT_W];
    grant_idx   = rr_result[GRANT_W-1:0];
    grant_en    = (state == IDLE) && !ack_s && grant_found;
  end

  // Steer the winner's word toward the channel register and raise its one-hot ready strobe
  always_comb begin
    grant_word = '0;
    o_ready    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == GRANT_W'(k)) begin
        grant_word = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_ready[k] = grant_en;
      end
    end
  end

  // Handshake FSM with registered req/data/id/busy and the round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      ptr        <= GRANT_W'(NUM_REQ - 1);
      o_cdc_req  <= 1'b0;
      o_cdc_data <= '0;
      o_cdc_id   <= '0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            o_cdc_data <= grant_word;
            o_cdc_id   <= grant_idx[ID_WIDTH-1:0];
            o_cdc_req  <= 1'b1;
            ptr        <= grant_idx;
            o_busy     <= 1'b1;
            state      <= REQ_HIGH;
          end
        end
        REQ_HIGH: begin
          if (ack_s) begin
            o_cdc_req <= 1'b0;
            state     <= REQ_LOW;
          end
        end
        REQ_LOW: begin
          if (!ack_s) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          o_cdc_req <= 1'b0;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // At most one requester is ever accepted per cycle
  a_ready_onehot : assert property (@(posedge i_clk) disable iff (!i_rst)
    $onehot0(o_ready));

  // No accept strobe while a transfer is in flight
  a_ready_idle_only : assert property (@(posedge i_clk) disable iff (!i_rst)
    (state != IDLE) |-> (o_ready == '0));

  // Request is only asserted during the request-high phase
  a_req_phase : assert property (@(posedge i_clk) disable iff (!i_rst)
    o_cdc_req |-> (state == REQ_HIGH));

endmodule
